ctrl_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer that drives the DataPath control strobes for instruction fetch and ALU/MUL/DIV execution. It replaces hand-sequenced T0–T5 stimulus with a Moore state machine. It adds a memory-ready handshake, a two-result HI/LO write-back step and a halt opcode. It sits between the IR output and every DataPath in/out enable.

---
 rtl/ctrl_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Moore control sequencer for the DataPath: fetch with a memory-ready wait state,
// then 3-register ALU ops or two-result MUL/DIV with HI/LO write-back, plus halt.
`timescale 1ns/1ps
module ctrl_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_COUNT    = 16,
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] MUL_OPCODE  = 5'b01111,
  parameter logic [OPCODE_WIDTH-1:0] DIV_OPCODE  = 5'b10000,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b11011
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    run,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   ir,
  output logic                    PCout,
  output logic                    MARin,
  output logic                    IncPC,
  output logic                    Zin,
  output logic                    Zlowout,
  output logic                    Zhighout,
  output logic                    PCin,
  output logic                    Read,
  output logic                    MDRin,
  output logic                    MDRout,
  output logic                    IRin,
  output logic                    Yin,
  output logic                    HIin,
  output logic                    LOin,
  output logic [REG_COUNT-1:0]    Rout,
  output logic [REG_COUNT-1:0]    Rin,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    halted,
  output logic [3:0]              state_dbg
);

  localparam int unsigned REG_SEL_WIDTH = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned FIELD_MSB     = DATA_WIDTH - OPCODE_WIDTH - 1;
  localparam int unsigned LOW_BITS      = DATA_WIDTH - OPCODE_WIDTH - 3 * REG_SEL_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  state_e state_q, state_d;

  logic [OPCODE_WIDTH-1:0]  opc_c;
  logic [REG_SEL_WIDTH-1:0] ra_c, rb_c, rc_c;
  logic                     is_md_c, is_halt_c;
  logic                     unused_ir_c;

  assign opc_c       = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ra_c        = ir[FIELD_MSB -: REG_SEL_WIDTH];
  assign rb_c        = ir[FIELD_MSB - REG_SEL_WIDTH -: REG_SEL_WIDTH];
  assign rc_c        = ir[FIELD_MSB - 2 * REG_SEL_WIDTH -: REG_SEL_WIDTH];
  assign is_md_c     = (opc_c == MUL_OPCODE) || (opc_c == DIV_OPCODE);
  assign is_halt_c   = (opc_c == HALT_OPCODE);
  assign unused_ir_c = ^ir[LOW_BITS-1:0];
  assign state_dbg   = state_q;

  // Selects beyond REG_COUNT-1 decode to all-zero so no register is touched
  function automatic logic [REG_COUNT-1:0] onehot(input logic [REG_SEL_WIDTH-1:0] sel);
    logic [REG_COUNT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (32'(sel) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    opcode   = '0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      // ir holds the freshly fetched instruction from here on
      S_T3: begin
        if (is_halt_c) begin
          state_d = S_HALT;
        end else begin
          Yin     = 1'b1;
          Rout    = is_md_c ? onehot(ra_c) : onehot(rb_c);
          state_d = S_T4;
        end
      end
      S_T4: begin
        opcode  = opc_c;
        Zin     = 1'b1;
        Rout    = is_md_c ? onehot(rb_c) : onehot(rc_c);
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md_c) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          Rin     = onehot(ra_c);
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: reset, ADD, wait states, MUL, back-to-back, halt.
`timescale 1ns/1ps
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin;
  logic MDRout, IRin, Yin, HIin, LOin, halted;
  logic [15:0] Rout, Rin;
  logic [4:0]  opcode;
  logic [3:0]  state_dbg;
  logic [13:0] strb;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T1W = 4'd3,
                         ST_T2 = 4'd4, ST_T3 = 4'd5, ST_T4 = 4'd6, ST_T5 = 4'd7,
                         ST_T6 = 4'd8, ST_HALT = 4'd9;
  // strobe vector order: PCout MARin IncPC Zin Zlowout Zhighout PCin Read MDRin MDRout IRin Yin HIin LOin
  localparam logic [13:0] SB_NONE = 14'h0000, SB_T0 = 14'h3C00, SB_T1 = 14'h02E0,
                          SB_T1W = 14'h0060, SB_T2 = 14'h0018, SB_T3 = 14'h0004,
                          SB_T4 = 14'h0400, SB_T5A = 14'h0200, SB_T5M = 14'h0201,
                          SB_T6 = 14'h0102;

  localparam logic [31:0] IR_ADD  = {5'b00100, 4'd4, 4'd3, 4'd7, 15'd0};
  localparam logic [31:0] IR_MUL  = {5'b01111, 4'd2, 4'd5, 4'd0, 15'd0};
  localparam logic [31:0] IR_HALT = {5'b11011, 4'd1, 4'd2, 4'd3, 15'd0};

  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
                 MDRout, IRin, Yin, HIin, LOin};

  ctrl_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin),
    .opcode(opcode), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [13:0] s,
                           input logic [15:0] ro, input logic [15:0] ri, input logic [4:0] op);
    chk({tag, ".state"},  32'(state_dbg), 32'(st));
    chk({tag, ".strobe"}, 32'(strb),      32'(s));
    chk({tag, ".Rout"},   32'(Rout),      32'(ro));
    chk({tag, ".Rin"},    32'(Rin),       32'(ri));
    chk({tag, ".opcode"}, 32'(opcode),    32'(op));
    chk({tag, ".halted"}, 32'(halted),    32'(st == ST_HALT));
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    clear = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = IR_ADD;
    #1;
    expect_st("reset", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);
    @(negedge clock);
    clear = 1'b1;
    tick();
    expect_st("idle_run0", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);

    // ADD r4,r3,r7; run dropped after T0 must not abort the instruction
    run = 1'b1;
    tick(); expect_st("add.T0", ST_T0, SB_T0, 16'h0, 16'h0, 5'd0);
    run = 1'b0;
    tick(); expect_st("add.T1", ST_T1, SB_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("add.T2", ST_T2, SB_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("add.T3", ST_T3, SB_T3, 16'h0008, 16'h0, 5'd0);
    tick(); expect_st("add.T4", ST_T4, SB_T4, 16'h0080, 16'h0, 5'b00100);
    tick(); expect_st("add.T5", ST_T5, SB_T5A, 16'h0, 16'h0010, 5'd0);
    tick(); expect_st("add.end", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);

    // MUL r2,r5 with three wait states in fetch
    ir = IR_MUL; run = 1'b1; mem_ready = 1'b0;
    tick(); expect_st("mul.T0", ST_T0, SB_T0, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("mul.T1", ST_T1, SB_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("mul.T1W1", ST_T1W, SB_T1W, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("mul.T1W2", ST_T1W, SB_T1W, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("mul.T1W3", ST_T1W, SB_T1W, 16'h0, 16'h0, 5'd0);
    mem_ready = 1'b1;
    tick(); expect_st("mul.T2", ST_T2, SB_T2, 16'h0, 16'h0, 5'd0);
    mem_ready = 1'b0;
    tick(); expect_st("mul.T3", ST_T3, SB_T3, 16'h0004, 16'h0, 5'd0);
    run = 1'b0;
    tick(); expect_st("mul.T4", ST_T4, SB_T4, 16'h0020, 16'h0, 5'b01111);
    tick(); expect_st("mul.T5", ST_T5, SB_T5M, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("mul.T6", ST_T6, SB_T6, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("mul.end", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);

    // Two ADDs back to back with no bubble
    ir = IR_ADD; run = 1'b1; mem_ready = 1'b1;
    tick(); expect_st("b2b.T0a", ST_T0, SB_T0, 16'h0, 16'h0, 5'd0);
    repeat (4) tick();
    expect_st("b2b.T4a", ST_T4, SB_T4, 16'h0080, 16'h0, 5'b00100);
    tick(); expect_st("b2b.T5a", ST_T5, SB_T5A, 16'h0, 16'h0010, 5'd0);
    tick(); expect_st("b2b.T0b", ST_T0, SB_T0, 16'h0, 16'h0, 5'd0);
    run = 1'b0;
    repeat (4) tick();
    expect_st("b2b.T4b", ST_T4, SB_T4, 16'h0080, 16'h0, 5'b00100);
    tick(); expect_st("b2b.T5b", ST_T5, SB_T5A, 16'h0, 16'h0010, 5'd0);
    tick(); expect_st("b2b.end", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);

    // Asynchronous clear in the middle of T4
    run = 1'b1;
    repeat (5) tick();
    expect_st("rst.T4", ST_T4, SB_T4, 16'h0080, 16'h0, 5'b00100);
    run = 1'b0;
    #1 clear = 1'b0;
    #1 expect_st("rst.async", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);
    @(negedge clock);
    clear = 1'b1;
    tick(); expect_st("rst.idle1", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);
    tick(); expect_st("rst.idle2", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);

    // HALT opcode: halted for 20 cycles whatever run/mem_ready do
    ir = IR_HALT; run = 1'b1;
    repeat (4) tick();
    expect_st("halt.T3", ST_T3, SB_NONE, 16'h0, 16'h0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_st("halt.hold", ST_HALT, SB_NONE, 16'h0, 16'h0, 5'd0);
      run       = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
    end
    run = 1'b0;
    clear = 1'b0;
    #1 expect_st("halt.clear", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);
    @(negedge clock);
    clear = 1'b1;
    tick(); expect_st("halt.idle", ST_IDLE, SB_NONE, 16'h0, 16'h0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
